puf_flow_sequencer: RTL and testbench

// Sequences one challenge through the PUF -> err_correction -> sha256_core chain.

---
 rtl/puf_flow_pkg.sv | 29 ++
 rtl/puf_wait_timer.sv | 44 ++++
 rtl/puf_flow_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_puf_flow_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module : puf_flow_pkg
// Brief  : Mode codes and FSM state encoding for the PUF flow sequencer.
// Rev    : 1.0
// ============================================================================
package puf_flow_pkg;

    localparam logic [1:0] MODE_RAW    = 2'b00;
    localparam logic [1:0] MODE_CORR   = 2'b01;
    localparam logic [1:0] MODE_HASH   = 2'b10;
    localparam logic [1:0] MODE_ENROLL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUF_WAIT  = 3'd1,
        ST_EC_WAIT   = 3'd2,
        ST_SHA_WAIT  = 3'd3,
        ST_SHA_CLR   = 3'd4,
        ST_ENROLL_WR = 3'd5,
        ST_DELIVER   = 3'd6
    } state_e;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_PUF_WAIT) || (s == ST_EC_WAIT) || (s == ST_SHA_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : puf_wait_timer
// Brief  : Wait-state cycle counter; expired marks the TIMEOUT_CYC-th cycle.
// Rev    : 1.0
// ============================================================================
module puf_wait_timer #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int TMR_W       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // count_q holds the number of cycles already completed in the wait state
    assign expired_o = enable_i && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_flow_sequencer.sv
`default_nettype none
// ============================================================================
// Module : puf_flow_sequencer
// Brief  : Sequences one challenge through PUF -> err_correction -> sha256.
// Rev    : 1.0
// ============================================================================
module puf_flow_sequencer
    import puf_flow_pkg::*;
#(
    parameter int RESP_W      = 256,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TMR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              puf_start,
    input  logic              puf_done,
    input  logic [RESP_W-1:0] puf_response,
    output logic              ec_start,
    input  logic              ec_ready,
    input  logic [RESP_W-1:0] ec_corrected,
    output logic              sha_init,
    output logic              sha_reset_n,
    input  logic              sha_digest_valid,
    input  logic [255:0]      sha_digest,
    output logic              mem_we,
    output logic [RESP_W-1:0] response,
    output logic              response_DV,
    output logic              busy,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              puf_start_q, puf_start_d;
    logic              ec_start_q, ec_start_d;
    logic              sha_init_q, sha_init_d;
    logic              sha_rst_n_q, sha_rst_n_d;
    logic              mem_we_q, mem_we_d;
    logic              dv_q, dv_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;
    logic              tmr_expired;

    puf_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (state_d != state_q),
        .enable_i  (is_wait_state(state_q)),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        resp_d      = resp_q;
        tmo_d       = tmo_q;
        puf_start_d = 1'b0;
        ec_start_d  = 1'b0;
        sha_init_d  = 1'b0;
        mem_we_d    = 1'b0;
        dv_d        = 1'b0;
        sha_rst_n_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    tmo_d       = 1'b0;
                    puf_start_d = 1'b1;
                    state_d     = ST_PUF_WAIT;
                end
            end
            ST_PUF_WAIT: begin
                // the done pulse takes priority over an expiry in the same cycle
                if (puf_done) begin
                    if (mode_q == MODE_RAW) begin
                        resp_d  = puf_response;
                        dv_d    = 1'b1;
                        state_d = ST_DELIVER;
                    end else if (mode_q == MODE_ENROLL) begin
                        mem_we_d = 1'b1;
                        state_d  = ST_ENROLL_WR;
                    end else begin
                        ec_start_d = 1'b1;
                        state_d    = ST_EC_WAIT;
                    end
                end else if (tmr_expired) begin
                    tmo_d       = 1'b1;
                    sha_rst_n_d = 1'b0;
                    state_d     = ST_SHA_CLR;
                end
            end
            ST_EC_WAIT: begin
                if (ec_ready) begin
                    if (mode_q == MODE_CORR) begin
                        resp_d  = ec_corrected;
                        dv_d    = 1'b1;
                        state_d = ST_DELIVER;
                    end else begin
                        sha_init_d = 1'b1;
                        state_d    = ST_SHA_WAIT;
                    end
                end else if (tmr_expired) begin
                    tmo_d       = 1'b1;
                    sha_rst_n_d = 1'b0;
                    state_d     = ST_SHA_CLR;
                end
            end
            ST_SHA_WAIT: begin
                if (sha_digest_valid) begin
                    resp_d      = RESP_W'(sha_digest);
                    sha_rst_n_d = 1'b0;
                    state_d     = ST_SHA_CLR;
                end else if (tmr_expired) begin
                    tmo_d       = 1'b1;
                    sha_rst_n_d = 1'b0;
                    state_d     = ST_SHA_CLR;
                end
            end
            ST_SHA_CLR: begin
                // an aborted flow shares the clear cycle but never delivers
                if (tmo_q) begin
                    state_d = ST_IDLE;
                end else begin
                    dv_d    = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_ENROLL_WR: state_d = ST_IDLE;
            ST_DELIVER:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RAW;
            resp_q      <= '0;
            tmo_q       <= 1'b0;
            puf_start_q <= 1'b0;
            ec_start_q  <= 1'b0;
            sha_init_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            dv_q        <= 1'b0;
            busy_q      <= 1'b0;
            sha_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            resp_q      <= resp_d;
            tmo_q       <= tmo_d;
            puf_start_q <= puf_start_d;
            ec_start_q  <= ec_start_d;
            sha_init_q  <= sha_init_d;
            mem_we_q    <= mem_we_d;
            dv_q        <= dv_d;
            busy_q      <= busy_d;
            sha_rst_n_q <= sha_rst_n_d;
        end
    end

    assign puf_start   = puf_start_q;
    assign ec_start    = ec_start_q;
    assign sha_init    = sha_init_q;
    assign sha_reset_n = sha_rst_n_q;
    assign mem_we      = mem_we_q;
    assign response    = resp_q;
    assign response_DV = dv_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_flow_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_puf_flow_sequencer
// Brief  : Randomized transaction bench with an event-schedule reference model.
// Rev    : 1.0
// ============================================================================
module tb_puf_flow_sequencer;

    localparam int RESP_W = 256;
    localparam int TO     = 24;
    localparam int TW     = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         puf_done = 1'b0;
    logic [255:0] puf_response = '0;
    logic         ec_ready = 1'b0;
    logic [255:0] ec_corrected = '0;
    logic         sha_digest_valid = 1'b0;
    logic [255:0] sha_digest = '0;
    logic         puf_start, ec_start, sha_init, sha_reset_n, mem_we;
    logic         response_DV, busy, timeout_err;
    logic [255:0] response;

    puf_flow_sequencer #(
        .RESP_W      (RESP_W),
        .TIMEOUT_CYC (TO),
        .TMR_W       (TW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .mode             (mode),
        .puf_start        (puf_start),
        .puf_done         (puf_done),
        .puf_response     (puf_response),
        .ec_start         (ec_start),
        .ec_ready         (ec_ready),
        .ec_corrected     (ec_corrected),
        .sha_init         (sha_init),
        .sha_reset_n      (sha_reset_n),
        .sha_digest_valid (sha_digest_valid),
        .sha_digest       (sha_digest),
        .mem_we           (mem_we),
        .response         (response),
        .response_DV      (response_DV),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           total = 0;
    int           bad = 0;
    logic [255:0] last_resp = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return TO;
        if (r == 1) return TO + 1;
        return $urandom_range(1, 6);
    endfunction

    // Caller is positioned at a negedge with the DUT idle.
    task automatic run_txn(input logic [1:0] m, input int d1, input int d2, input int d3,
                           input logic [255:0] vp, input logic [255:0] vc, input logic [255:0] vh);
        int S, X, pd, ed, hd, end_e;
        int dv_e, mw_e, ec_e, si_e, clr_e;
        int n_ps, n_ec, n_si, n_mw, n_dv, n_clr, f_ps, f_ec, f_si, f_mw, f_dv, f_clr;
        int busy_bad;
        logic         tmo, stray, tmo_at_s;
        logic [255:0] er, resp_at_dv;

        S = cyc + 1;
        tmo = 1'b0; X = 0; ed = -1; hd = -1; end_e = 0;
        dv_e = -1; mw_e = -1; ec_e = -1; si_e = -1; clr_e = -1;
        er = last_resp;
        pd = S + d1;
        if (d1 > TO) begin
            tmo = 1'b1; X = S + TO;
        end else if (m == 2'b00) begin
            dv_e = pd; er = vp; end_e = pd + 1;
        end else if (m == 2'b11) begin
            mw_e = pd; end_e = pd + 1;
        end else begin
            ec_e = pd; ed = pd + d2;
            if (d2 > TO) begin
                tmo = 1'b1; X = pd + TO;
            end else if (m == 2'b01) begin
                dv_e = ed; er = vc; end_e = ed + 1;
            end else begin
                si_e = ed; hd = ed + d3;
                if (d3 > TO) begin
                    tmo = 1'b1; X = ed + TO;
                end else begin
                    clr_e = hd; dv_e = hd + 1; er = vh; end_e = hd + 2;
                end
            end
        end
        if (tmo) begin
            clr_e = X; end_e = X + 1;
        end

        stray = (d1 >= 2);
        n_ps = 0; n_ec = 0; n_si = 0; n_mw = 0; n_dv = 0; n_clr = 0;
        f_ps = -1; f_ec = -1; f_si = -1; f_mw = -1; f_dv = -1; f_clr = -1;
        busy_bad = 0; tmo_at_s = 1'bx; resp_at_dv = '0;

        for (int e = S; e <= end_e + 1; e++) begin
            start            = (e == S) || (stray && e == S + 1);
            mode             = (e == S) ? m : 2'($urandom);
            puf_done         = (e == pd);
            ec_ready         = (e == ed) || (stray && e == S + 1);
            sha_digest_valid = (e == hd);
            puf_response     = (e == pd) ? vp : rand256();
            ec_corrected     = (e == ed) ? vc : rand256();
            sha_digest       = (e == hd) ? vh : rand256();
            @(posedge clk);
            #1;
            if (puf_start)    begin n_ps++;  if (f_ps  < 0) f_ps  = e; end
            if (ec_start)     begin n_ec++;  if (f_ec  < 0) f_ec  = e; end
            if (sha_init)     begin n_si++;  if (f_si  < 0) f_si  = e; end
            if (mem_we)       begin n_mw++;  if (f_mw  < 0) f_mw  = e; end
            if (!sha_reset_n) begin n_clr++; if (f_clr < 0) f_clr = e; end
            if (response_DV)  begin n_dv++;  if (f_dv  < 0) begin f_dv = e; resp_at_dv = response; end end
            if (busy !== (e < end_e)) busy_bad++;
            if (e == S) tmo_at_s = timeout_err;
            @(negedge clk);
        end
        start = 1'b0; puf_done = 1'b0; ec_ready = 1'b0; sha_digest_valid = 1'b0;

        chk("puf_start_cyc", f_ps, S);
        chk("puf_start_n", n_ps, 1);
        chk("ec_start_cyc", f_ec, ec_e);
        chk("ec_start_n", n_ec, (ec_e >= 0) ? 1 : 0);
        chk("sha_init_cyc", f_si, si_e);
        chk("sha_init_n", n_si, (si_e >= 0) ? 1 : 0);
        chk("mem_we_cyc", f_mw, mw_e);
        chk("mem_we_n", n_mw, (mw_e >= 0) ? 1 : 0);
        chk("sha_clr_cyc", f_clr, clr_e);
        chk("sha_clr_n", n_clr, (clr_e >= 0) ? 1 : 0);
        chk("dv_cyc", f_dv, dv_e);
        chk("dv_n", n_dv, (dv_e >= 0) ? 1 : 0);
        if (dv_e >= 0) chk("resp_at_dv", resp_at_dv, er);
        chk("resp_hold", response, er);
        chk("tmo_cleared_on_start", tmo_at_s, 1'b0);
        chk("tmo_end", timeout_err, tmo);
        chk("busy_profile", busy_bad, 0);
        last_resp = er;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idle_dv, idle_busy;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sha_reset_n", sha_reset_n, 1'b0);
        chk("rst_strobes", {puf_start, ec_start, sha_init, mem_we, response_DV}, 5'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_response", response, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_sha_reset_n", sha_reset_n, 1'b1);
        chk("idle_busy", busy, 1'b0);
        @(negedge clk);

        run_txn(2'b00, 20, 1, 1, {32{8'hA5}}, rand256(), rand256());
        run_txn(2'b10, 3, 4, 5, rand256(), rand256(), {16{16'h1234}});
        run_txn(2'b11, 2, 1, 1, rand256(), rand256(), rand256());
        run_txn(2'b00, TO + 1, 1, 1, rand256(), rand256(), rand256());
        run_txn(2'b01, TO, 2, 1, rand256(), rand256(), rand256());
        run_txn(2'b10, 1, TO + 1, 1, rand256(), rand256(), rand256());
        run_txn(2'b10, 1, 1, TO + 1, rand256(), rand256(), rand256());

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(2'($urandom), rand_delay(), rand_delay(), rand_delay(),
                    rand256(), rand256(), rand256());
        end

        // reset asserted while waiting on err_correction
        start = 1'b1; mode = 2'b10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        puf_done = 1'b1;
        @(negedge clk);
        puf_done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_strobes", {puf_start, ec_start, sha_init, mem_we, response_DV}, 5'b0);
        chk("midrst_sha_reset_n", sha_reset_n, 1'b0);
        chk("midrst_response", response, '0);
        @(negedge clk);
        reset_n = 1'b1;
        ec_ready = 1'b1;
        sha_digest_valid = 1'b1;
        idle_dv = 0; idle_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (response_DV || ec_start || sha_init) idle_dv++;
            if (busy) idle_busy++;
            @(negedge clk);
            ec_ready = 1'b0;
            sha_digest_valid = 1'b0;
        end
        chk("postrst_no_strobes", idle_dv, 0);
        chk("postrst_idle", idle_busy, 0);
        last_resp = '0;

        run_txn(2'b01, 3, 2, 1, rand256(), rand256(), rand256());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
